mux8_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 8:1 datapath multiplexer. Eight requesters compete for the mux; the block grants one at a time, drives the mux `select[2:0]`/`enable` directly, and enforces a bounded hold time with a break-before-make idle cycle between owners. It sits between the requesting units and the mux instance, which is otherwise unchanged.

---
 rtl/mux8_arbiter_pkg.sv | 19 +
 rtl/mux8_arbiter_if.sv | 24 ++
 rtl/mux8_arbiter_rr_pick8.sv | 28 ++
 rtl/mux8_arbiter.sv | 89 ++++++++
 tb/tb_mux8_arbiter.sv | 127 ++++++++++++
 5 files changed

// File: rtl/mux8_arbiter_pkg.sv
// Shared definitions for the 8:1 mux arbiter: state encoding, sizes
// and a one-hot helper. Imported by the interface, picker and top.
package mux8_arb_pkg;

    localparam int NUM_REQ   = 8;
    localparam int SEL_WIDTH = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(
        input logic [SEL_WIDTH-1:0] idx
    );
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux8_arbiter_if.sv
// Request/grant bundle between the requesting units and the arbiter.
// Ports: req[7:0], done (requester side); grant[7:0], select[2:0],
// enable, timeout (arbiter side). master = requesters, slave = arbiter.
interface mux8_arbiter_if;
    import mux8_arb_pkg::*;

    logic [NUM_REQ-1:0]   req;
    logic                 done;
    logic [NUM_REQ-1:0]   grant;
    logic [SEL_WIDTH-1:0] select;
    logic                 enable;
    logic                 timeout;

    modport master (
        output req, done,
        input  grant, select, enable, timeout
    );

    modport slave (
        input  req, done,
        output grant, select, enable, timeout
    );

endinterface

// File: rtl/mux8_arbiter_rr_pick8.sv
// Round-robin picker: rotates req so ptr is bit 0, then priority
// encodes. Ports: req[7:0], ptr[2:0] in; found, index[2:0] out.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] index
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NUM_REQ-1:0];
        found = |rot;
        index = ptr;
        // Scan from the top down so the lowest rotated bit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                index = ptr + SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter driving the shared 8:1 mux select/enable with a
// bounded hold and one idle cycle between owners.
// Ports: clk, reset (async, active-high), bus (slave modport).
module mux8_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD  = 15,
    parameter int CNT_WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    mux8_arbiter_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LIM = CNT_WIDTH'(MAX_HOLD);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] owner_q, owner_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] hold_q, hold_d;
    logic                 tmo_q, tmo_d;

    logic                 found;
    logic [SEL_WIDTH-1:0] pick;
    logic                 at_lim;
    logic                 user_rel;

    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (found),
        .index (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        tmo_d    = 1'b0;
        at_lim   = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);
        user_rel = bus.done || !bus.req[owner_q];
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    hold_d  = CNT_ONE;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (user_rel || at_lim) begin
                    state_d = IDLE;
                    ptr_d   = owner_q + SEL_WIDTH'(1);
                    hold_d  = '0;
                    // Only a pure hold-limit revoke counts as a timeout.
                    tmo_d   = at_lim && !user_rel;
                end else if (hold_q != CNT_MAX) begin
                    hold_d = hold_q + CNT_ONE;
                end
            end
        endcase
    end

    // Decoded from registers only, so reset clears them asynchronously.
    assign bus.grant   = (state_q == GRANT) ? onehot(owner_q) : '0;
    assign bus.select  = (state_q == GRANT) ? owner_q : '0;
    assign bus.enable  = (state_q == GRANT);
    assign bus.timeout = tmo_q;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed self-checking bench for mux8_arbiter (MAX_HOLD=15).
// Inputs change and outputs are sampled on the falling edge.
module tb_mux8_arbiter;
    import mux8_arb_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mux8_arbiter_if bus ();

    mux8_arbiter #(
        .MAX_HOLD  (15),
        .CNT_WIDTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g,
                           input logic [2:0] s, input logic t);
        chk({tag, ".grant"}, bus.grant, g);
        chk({tag, ".select"}, {5'd0, bus.select}, {5'd0, s});
        chk({tag, ".enable"}, {7'd0, bus.enable}, {7'd0, (g != 8'h00)});
        chk({tag, ".timeout"}, {7'd0, bus.timeout}, {7'd0, t});
    endtask

    initial begin
        logic [2:0] k3;
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        tick();
        tick();
        chk_out("reset", 8'h00, 3'd0, 1'b0);

        // Release reset; first edge grants requester 0.
        reset = 1'b0;
        tick();
        chk_out("first", 8'h01, 3'd0, 1'b0);

        // Round robin with done on each first grant cycle.
        bus.done = 1'b1;
        tick();
        chk_out("rr_rel0", 8'h00, 3'd0, 1'b0);
        bus.done = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            k3 = 3'(k);
            tick();
            chk_out($sformatf("rr_g%0d", k), 8'h01 << k3, k3, 1'b0);
            bus.done = 1'b1;
            tick();
            chk_out($sformatf("rr_i%0d", k), 8'h00, 3'd0, 1'b0);
            bus.done = 1'b0;
        end

        // Single persistent requester 3: 15-cycle grant, then timeout.
        bus.req = 8'h08;
        for (int n = 1; n <= 15; n++) begin
            tick();
            chk_out($sformatf("hold%0d", n), 8'h08, 3'd3, 1'b0);
        end
        tick();
        chk_out("tmo", 8'h00, 3'd0, 1'b1);
        tick();
        chk_out("regrant", 8'h08, 3'd3, 1'b0);

        // done coincides with hold limit: no timeout.
        for (int n = 2; n <= 15; n++) tick();
        chk_out("hold15b", 8'h08, 3'd3, 1'b0);
        bus.done = 1'b1;
        tick();
        chk_out("coinc", 8'h00, 3'd0, 1'b0);
        bus.done = 1'b0;
        tick();
        chk_out("regrant2", 8'h08, 3'd3, 1'b0);

        // Drop req[3], then get owner 5, then drop req[5] with req[2] set.
        bus.req = 8'h00;
        tick();
        chk_out("drop3", 8'h00, 3'd0, 1'b0);
        bus.req = 8'h20;
        tick();
        chk_out("own5", 8'h20, 3'd5, 1'b0);
        bus.req = 8'h04;
        tick();
        chk_out("drop5", 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("wrap2", 8'h04, 3'd2, 1'b0);

        // Async reset between edges drops grant at once.
        bus.req = 8'hFF;
        #2;
        reset = 1'b1;
        #1;
        chk_out("async", 8'h00, 3'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk_out("ptr0", 8'h01, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
